// File: rtl/button_pkg.sv
// Shared constants for the button event counter slice.
//   DEF_*          default parameter values for the top, interface and debouncer
//   MODE_WRAP      counter rolls over from max to 0 (ovf_o sets on the roll)
//   MODE_SATURATE  counter sticks at max (ovf_o sets on the first press at max)
package button_pkg;

    localparam int unsigned DEF_N_CH     = 3;
    localparam int unsigned DEF_FILT_LEN = 8;
    localparam int unsigned DEF_CNT_W    = 8;

    localparam int unsigned MODE_WRAP     = 0;
    localparam int unsigned MODE_SATURATE = 1;

endpackage

// File: rtl/button_event_counter_if.sv
// Bus bundle for button_event_counter.
//   btn_i      raw button levels (asynchronous, bouncing), 1 = pressed
//   clr_i      per-channel synchronous clear of counter and overflow flag
//   state_o    debounced level
//   press_o    one-cycle pulse on debounced 0->1
//   release_o  one-cycle pulse on debounced 1->0
//   cnt_o      packed press counters, channel i at [i*CNT_W +: CNT_W]
//   ovf_o      sticky overflow flags
// slave is the design side, master is the driver side.
interface button_event_counter_if
    import button_pkg::*;
#(
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic [N_CH-1:0]       btn_i;
    logic [N_CH-1:0]       clr_i;
    logic [N_CH-1:0]       state_o;
    logic [N_CH-1:0]       press_o;
    logic [N_CH-1:0]       release_o;
    logic [N_CH*CNT_W-1:0] cnt_o;
    logic [N_CH-1:0]       ovf_o;

    modport slave (
        input  btn_i, clr_i,
        output state_o, press_o, release_o, cnt_o, ovf_o
    );

    modport master (
        output btn_i, clr_i,
        input  state_o, press_o, release_o, cnt_o, ovf_o
    );
endinterface

// File: rtl/button_debounce.sv
// Single-channel debouncer: 2-flop synchroniser, sample history, hysteretic
// debounced state and registered edge pulses.
//   clk, rst     clock, asynchronous active-high reset
//   btn_i        raw asynchronous button level
//   state_o      debounced level (registered)
//   press_o      registered pulse, high in the first cycle state_o shows 1
//   release_o    registered pulse, high in the first cycle state_o shows 0
//   press_evt_o  combinational: the coming edge sets state_o (drives the counter)
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic press_evt_o
);
    logic                sync1_q, sync2_q;
    // Only FILT_LEN-1 older samples are stored; together with sync2_q they form
    // the FILT_LEN-sample window, so state flips on the edge the window fills.
    logic [FILT_LEN-2:0] hist_q;
    logic [FILT_LEN-1:0] hist_d;
    logic                state_q, state_d;
    logic                press_q, release_q;

    always_comb begin
        hist_d = {hist_q, sync2_q};
        state_d = state_q;
        if (&hist_d) begin
            state_d = 1'b1;
        end else if (~|hist_d) begin
            state_d = 1'b0;
        end
    end

    assign press_evt_o = state_d & ~state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            hist_q    <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            hist_q    <= hist_d[FILT_LEN-2:0];
            state_q   <= state_d;
            press_q   <= state_d & ~state_q;
            release_q <= ~state_d & state_q;
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;
endmodule

// File: rtl/button_event_counter.sv
// Multi-channel debounced button event counter.
//   clk, rst  clock, asynchronous active-high reset
//   bus       button_event_counter_if slave: btn_i/clr_i in; state_o, press_o,
//             release_o, cnt_o, ovf_o out
// Each channel has its own debouncer and press counter; a clear beats a
// coincident press on the counter but never touches the debounce path.
module button_event_counter
    import button_pkg::*;
#(
    parameter int unsigned N_CH     = DEF_N_CH,
    parameter int unsigned FILT_LEN = DEF_FILT_LEN,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic                   clk,
    input  logic                   rst,
    button_event_counter_if.slave  bus
);
    // Any value other than MODE_SATURATE behaves as wrap.
    localparam bit SAT_EN = (SATURATE != MODE_WRAP) && (SATURATE == MODE_SATURATE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0] state, press, release_p, press_evt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic             ovf_q;

        button_debounce #(
            .FILT_LEN (FILT_LEN)
        ) u_debounce (
            .clk         (clk),
            .rst         (rst),
            .btn_i       (bus.btn_i[i]),
            .state_o     (state[i]),
            .press_o     (press[i]),
            .release_o   (release_p[i]),
            .press_evt_o (press_evt[i])
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (bus.clr_i[i]) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (press_evt[i]) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_q <= 1'b1;
                    if (!SAT_EN) begin
                        cnt_q <= '0;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign bus.cnt_o[i*CNT_W +: CNT_W] = cnt_q;
        assign bus.ovf_o[i]                = ovf_q;
    end

    assign bus.state_o   = state;
    assign bus.press_o   = press;
    assign bus.release_o = release_p;
endmodule

// File: tb/tb_button_event_counter.sv
// Self-checking bench: two instances (wrap and saturate) share the same
// stimulus and are compared every cycle against a run-length based model.
module tb_button_event_counter;
    localparam int N = 3;
    localparam int F = 8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] clr = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_event_counter_if #(.N_CH(N), .CNT_W(W)) if_w ();
    button_event_counter_if #(.N_CH(N), .CNT_W(W)) if_s ();

    assign if_w.btn_i = btn;
    assign if_w.clr_i = clr;
    assign if_s.btn_i = btn;
    assign if_s.clr_i = clr;

    button_event_counter #(.N_CH(N), .FILT_LEN(F), .CNT_W(W), .SATURATE(0)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (if_w)
    );

    button_event_counter #(.N_CH(N), .FILT_LEN(F), .CNT_W(W), .SATURATE(1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (if_s)
    );

    // Model: the debounced state follows the raw samples two edges late; it
    // flips once F consecutive delayed samples agree.
    int ones_run[N];
    int zero_run[N];
    bit p1[N], p2[N];
    bit st_m[N], pr_m[N], rl_m[N];
    int cnt_m[2][N];
    bit ovf_m[2][N];

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            ones_run[ch] = 0;
            zero_run[ch] = F;
            p1[ch] = 1'b0;
            p2[ch] = 1'b0;
            st_m[ch] = 1'b0;
            pr_m[ch] = 1'b0;
            rl_m[ch] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                cnt_m[m][ch] = 0;
                ovf_m[m][ch] = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input logic [N-1:0] b, input logic [N-1:0] c);
        bit old;
        for (int ch = 0; ch < N; ch++) begin
            old = st_m[ch];
            if (p2[ch]) begin
                ones_run[ch]++;
                zero_run[ch] = 0;
            end else begin
                zero_run[ch]++;
                ones_run[ch] = 0;
            end
            if (ones_run[ch] >= F) st_m[ch] = 1'b1;
            else if (zero_run[ch] >= F) st_m[ch] = 1'b0;
            p2[ch] = p1[ch];
            p1[ch] = b[ch];
            pr_m[ch] = st_m[ch] & ~old;
            rl_m[ch] = ~st_m[ch] & old;
            for (int m = 0; m < 2; m++) begin
                if (c[ch]) begin
                    cnt_m[m][ch] = 0;
                    ovf_m[m][ch] = 1'b0;
                end else if (pr_m[ch]) begin
                    if (cnt_m[m][ch] == (1 << W) - 1) begin
                        ovf_m[m][ch] = 1'b1;
                        if (m == 0) cnt_m[m][ch] = 0;
                    end else begin
                        cnt_m[m][ch]++;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int ch = 0; ch < N; ch++) begin
            chk($sformatf("state[%0d]", ch), 32'(if_w.state_o[ch]), 32'(st_m[ch]));
            chk($sformatf("press[%0d]", ch), 32'(if_w.press_o[ch]), 32'(pr_m[ch]));
            chk($sformatf("release[%0d]", ch), 32'(if_w.release_o[ch]), 32'(rl_m[ch]));
            chk($sformatf("wrap_cnt[%0d]", ch), 32'(if_w.cnt_o[ch*W +: W]), 32'(cnt_m[0][ch]));
            chk($sformatf("wrap_ovf[%0d]", ch), 32'(if_w.ovf_o[ch]), 32'(ovf_m[0][ch]));
            chk($sformatf("sat_state[%0d]", ch), 32'(if_s.state_o[ch]), 32'(st_m[ch]));
            chk($sformatf("sat_press[%0d]", ch), 32'(if_s.press_o[ch]), 32'(pr_m[ch]));
            chk($sformatf("sat_release[%0d]", ch), 32'(if_s.release_o[ch]), 32'(rl_m[ch]));
            chk($sformatf("sat_cnt[%0d]", ch), 32'(if_s.cnt_o[ch*W +: W]), 32'(cnt_m[1][ch]));
            chk($sformatf("sat_ovf[%0d]", ch), 32'(if_s.ovf_o[ch]), 32'(ovf_m[1][ch]));
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic step(input logic [N-1:0] b, input logic [N-1:0] c);
        btn = b;
        clr = c;
        @(posedge clk);
        model_edge(b, c);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [N-1:0] b, input logic [N-1:0] c, input int n);
        for (int i = 0; i < n; i++) step(b, c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int period;
        logic [N-1:0] cur;
        logic [N-1:0] c;

        model_reset();
        #2;
        check_all();
        chk("reset_cnt_o", 32'(if_w.cnt_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single press on ch0: state rises on the 10th sampling edge.
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            step(3'b001, 3'b000);
            seen += int'(if_w.press_o[0]);
            if (i == 9) chk("r032_state_before", 32'(if_w.state_o[0]), 32'd0);
            if (i == 10) begin
                chk("r032_state_rise", 32'(if_w.state_o[0]), 32'd1);
                chk("r032_press", 32'(if_w.press_o[0]), 32'd1);
                chk("r032_cnt0", 32'(if_w.cnt_o[7:0]), 32'd1);
            end
        end
        chk("r032_press_count", 32'(seen), 32'd1);
        chk("r032_other_cnt", 32'(if_w.cnt_o[23:8]), 32'd0);
        hold(3'b000, 3'b000, 12);

        // Seven-cycle glitch on ch1 must be rejected.
        seen = 0;
        for (int i = 0; i < 19; i++) begin
            step((i < 7) ? 3'b010 : 3'b000, 3'b000);
            seen += int'(if_w.press_o[1]) + int'(if_w.state_o[1]);
        end
        chk("r033_no_event", 32'(seen), 32'd0);
        chk("r033_cnt1", 32'(if_w.cnt_o[15:8]), 32'd0);

        // Clear coincident with the press edge.
        for (int i = 1; i <= 10; i++) begin
            step(3'b001, (i == 10) ? 3'b001 : 3'b000);
            if (i == 10) begin
                chk("r035_cnt0", 32'(if_w.cnt_o[7:0]), 32'd0);
                chk("r035_ovf0", 32'(if_w.ovf_o[0]), 32'd0);
                chk("r035_press0", 32'(if_w.press_o[0]), 32'd1);
            end
        end
        hold(3'b001, 3'b000, 3);
        hold(3'b000, 3'b000, 12);

        // All channels pressed together.
        step(3'b000, 3'b111);
        for (int i = 1; i <= 10; i++) begin
            step(3'b111, 3'b000);
            if (i == 10) begin
                chk("r037_press_all", 32'(if_w.press_o), 32'd7);
                chk("r037_cnt_w", 32'(if_w.cnt_o), 32'h010101);
                chk("r037_cnt_s", 32'(if_s.cnt_o), 32'h010101);
            end
        end
        hold(3'b000, 3'b000, 12);

        // 256 clean presses on ch2.
        step(3'b000, 3'b100);
        for (int p = 0; p < 256; p++) begin
            hold(3'b100, 3'b000, 10);
            hold(3'b000, 3'b000, 10);
        end
        chk("r034_wrap_cnt2", 32'(if_w.cnt_o[23:16]), 32'd0);
        chk("r034_wrap_ovf2", 32'(if_w.ovf_o[2]), 32'd1);
        chk("r034_sat_cnt2", 32'(if_s.cnt_o[23:16]), 32'd255);
        chk("r034_sat_ovf2", 32'(if_s.ovf_o[2]), 32'd1);
        chk("r034_ch0_untouched", 32'(if_w.cnt_o[7:0]), 32'd1);

        // Reset in the middle of a held press.
        step(3'b000, 3'b111);
        hold(3'b001, 3'b000, 5);
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("r036_all_zero", 32'({if_w.state_o, if_w.press_o, if_w.ovf_o}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(3'b001, 3'b000);
            if (i == 9) chk("r036_press_early", 32'(if_w.press_o[0]), 32'd0);
            if (i == 10) chk("r036_press", 32'(if_w.press_o[0]), 32'd1);
        end
        hold(3'b000, 3'b000, 12);

        // Random bouncing with blocks of differing toggle rates and random clears.
        cur = '0;
        period = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0:       period = 2;
                    1:       period = 6;
                    default: period = 30;
                endcase
            end
            c = '0;
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, period - 1) == 0) cur[ch] = ~cur[ch];
                if ($urandom_range(0, 39) == 0) c[ch] = 1'b1;
            end
            step(cur, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_event_counter.md
BUTTON_EVENT_COUNTER -- requirements
Module: button_event_counter

Interface
REQ-001 Parameter N_CH, default 3, number of independent button channels (left/right/middle).
REQ-002 Parameter FILT_LEN, default 8, number of consecutive equal samples required to change debounced state; legal range 2..32.
REQ-003 Parameter CNT_W, default 8, width of each per-channel press counter.
REQ-004 Parameter SATURATE, default 0, counter overflow mode: 0 = wrap, 1 = saturate.
REQ-005 clk  input  1  system clock; all state SHALL be clocked on its rising edge only.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 btn_i  input  N_CH  raw, asynchronous, bouncing button levels; 1 = pressed.
REQ-008 clr_i  input  N_CH  per-channel synchronous clear of counter and overflow flag.
REQ-009 state_o  output  N_CH  debounced button level.
REQ-010 press_o  output  N_CH  one-cycle pulse on debounced 0->1.
REQ-011 release_o  output  N_CH  one-cycle pulse on debounced 1->0.
REQ-012 cnt_o  output  N_CH*CNT_W  press counters; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-013 ovf_o  output  N_CH  sticky overflow flag per channel.

Function
REQ-014 Each btn_i bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-015 The synchronised bit SHALL shift into a FILT_LEN-bit history register every cycle.
REQ-016 state_o SHALL be set when the history is all ones, cleared when all zeros, and hold otherwise (hysteresis).
REQ-017 Latency: btn_i first sampled high at edge k and held high -> state_o high after edge k+1+FILT_LEN.
REQ-018 press_o/release_o SHALL be high exactly in the cycle in which state_o first shows its new value.
REQ-019 cnt_o SHALL increment on the same edge that sets state_o; releases do not count.
REQ-020 Wrap mode: increment from 2^CNT_W-1 SHALL yield 0 and set ovf_o.
REQ-021 Saturate mode: counter SHALL hold at 2^CNT_W-1, and ovf_o SHALL set on the first press attempted at max.
REQ-022 ovf_o SHALL remain set until clr_i or rst for that channel.
REQ-023 clr_i high at an edge SHALL set that channel's counter and ovf_o to 0; clear wins over a coincident press (count stays 0), but press_o still pulses.
REQ-024 clr_i SHALL NOT affect synchroniser, history, state_o or edge pulses.
REQ-025 Channels SHALL be fully independent; simultaneous events on any subset are all honoured in the same cycle.
REQ-026 No derived or gated clocks; no logic clocked by data signals.

Reset
REQ-027 rst SHALL asynchronously clear synchronisers, history, state_o, press_o, release_o, cnt_o and ovf_o to 0.
REQ-028 After rst deasserts with btn_i held high, a press SHALL be reported only after the full REQ-017 latency from the first edge sampled after rst deasserts.

Structure
REQ-029 Package button_pkg SHALL hold the default parameter values and the SATURATE mode constants.
REQ-030 Sub-module button_debounce (synchroniser, history, state, edge pulses) SHALL be instantiated once per channel via generate.
REQ-031 Counters and overflow logic SHALL reside in the top level.

Verification (N_CH=3, FILT_LEN=8, CNT_W=8)
REQ-032 btn_i[0] high for 20 cycles -> state_o[0] rises 9 edges after the first sampling edge, press_o[0] pulses once, cnt ch0 = 1, other channels unchanged.
REQ-033 btn_i[1] high for 7 cycles, then low -> no state_o, press_o or cnt change.
REQ-034 256 clean presses on ch2, SATURATE=0 -> cnt = 0, ovf_o[2] = 1; SATURATE=1 -> cnt = 255, ovf_o[2] = 1.
REQ-035 clr_i[0] asserted in the press cycle -> cnt ch0 = 0, ovf_o[0] = 0, press_o[0] = 1.
REQ-036 rst pulsed 5 cycles into a held press -> all outputs 0 immediately; the press is reported 9 edges after the first edge sampled after rst deasserts.
REQ-037 All three buttons pressed in the same cycle -> three press_o bits pulse in the same cycle, and each counter = 1.
